// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   Single-issue instruction fetch stage. It sits in front of a registered
//   instruction ROM, where data appears one clock edge after its address.
//   The stage delivers one word per cycle to the decode stage. It also
//   handles stall, redirect and halt.
//
// Ports
//   clock            single clock, all state updates on posedge
//   reset            synchronous, active-high
//   stall            downstream not ready; current output word not consumed
//   redirect         branch/jump taken; squash in-flight word and refetch
//   redirect_target  word address of the redirect destination
//   rom_address      word address presented to the registered ROM
//   rom_data         ROM output (bit 32 unused)
//   if_valid         if_instruction / if_pc hold a live fetched word
//   if_pc            word address of if_instruction
//   if_instruction   rom_data[31:0]
//   fetch_count      accepted words, saturating
//   debug_state      current FSM state (IDLE=0, RUN=1, HALT=2)
//
// Handshake: a word is offered whenever if_valid is 1. It is consumed
// ("accepted") on a clock edge where if_valid=1 and stall=0. While stall=1
// the same word, pc and valid are held stable. A redirect on any edge
// replaces the offered word.
//
// All PC values are word addresses modulo ROM_DEPTH.
// ---------------------------------------------------------------------------
module instruction_fetch #(
   parameter logic [31:0] RESET_PC    = 32'd0,
   parameter int          ROM_DEPTH   = 1024,
   parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic [31:0] rom_address,
   input  logic [32:0] rom_data,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instruction,
   output logic [31:0] fetch_count,
   output logic [1:0]  debug_state
);

   localparam int AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
   localparam logic [AW-1:0] RESET_PC_W = RESET_PC[AW-1:0];

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t        state, state_nx;
   logic [AW-1:0] fetch_pc, fetch_pc_nx;
   logic [AW-1:0] out_pc, out_pc_nx;
   logic          out_valid, out_valid_nx;
   logic [AW-1:0] target_pc;
   logic [AW-1:0] addr_w;
   logic          accept;
   logic          halt_word;

   // Upper target bits and the spare ROM bit are intentionally ignored.
   logic unused_bits;
   assign unused_bits = ^{rom_data[32], redirect_target};

   // Truncation gives the modulo-ROM_DEPTH wrap (ROM_DEPTH is a power of two).
   assign target_pc = redirect_target[AW-1:0];

   assign accept    = out_valid && !stall;
   assign halt_word = (if_instruction[31:26] == HALT_OPCODE);

   // The ROM is registered, so the address driven now is the word shown next
   // cycle. A stall re-reads out_pc to keep if_instruction stable.
   always_comb begin
      addr_w = fetch_pc;
      if (redirect)
         addr_w = target_pc;
      else if (out_valid && stall)
         addr_w = out_pc;
   end

   assign rom_address    = 32'(addr_w);
   assign if_instruction = rom_data[31:0];
   assign if_pc          = 32'(out_pc);
   assign if_valid       = out_valid;
   assign debug_state    = state;

   always_comb begin
      state_nx     = state;
      fetch_pc_nx  = fetch_pc;
      out_pc_nx    = out_pc;
      out_valid_nx = out_valid;
      if (redirect) begin
         // The redirect beats stall and halt. The held word is dropped.
         out_pc_nx    = target_pc;
         out_valid_nx = 1'b1;
         fetch_pc_nx  = target_pc + 1'b1;
         state_nx     = RUN;
      end else begin
         case (state)
            IDLE: begin
               out_pc_nx    = fetch_pc;
               out_valid_nx = 1'b1;
               fetch_pc_nx  = fetch_pc + 1'b1;
               state_nx     = RUN;
            end
            RUN: begin
               if (out_valid && stall) begin
                  // hold everything
               end else if (accept && halt_word) begin
                  out_valid_nx = 1'b0;
                  state_nx     = HALT;
               end else begin
                  out_pc_nx    = fetch_pc;
                  out_valid_nx = 1'b1;
                  fetch_pc_nx  = fetch_pc + 1'b1;
               end
            end
            HALT: begin
               out_valid_nx = 1'b0;
            end
            default: begin
               state_nx     = IDLE;
               out_valid_nx = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         fetch_pc  <= RESET_PC_W;
         out_pc    <= RESET_PC_W;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nx;
         fetch_pc  <= fetch_pc_nx;
         out_pc    <= out_pc_nx;
         out_valid <= out_valid_nx;
      end
   end

   always_ff @(posedge clock) begin
      if (reset)
         fetch_count <= 32'd0;
      else if (accept && (fetch_count != 32'hFFFF_FFFF))
         fetch_count <= fetch_count + 32'd1;
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch with a registered ROM model and a reference
// model that tracks the offered word as a (pc, valid) pair plus the next
// sequential address.
module tb_instruction_fetch;

   localparam int          DEPTH = 1024;
   localparam logic [31:0] RPC   = 32'd0;
   localparam logic [5:0]  HOP   = 6'b111111;

   logic        clock = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_target;
   logic [31:0] rom_address;
   logic [32:0] rom_data = 33'd0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instruction;
   logic [31:0] fetch_count;
   logic [1:0]  debug_state;

   logic [31:0] mem [DEPTH];

   int n_total = 0;
   int n_bad   = 0;

   // reference model state
   logic        m_valid;
   logic        m_halt;
   logic        m_idle;
   logic [31:0] m_pc;
   logic [31:0] m_next;
   logic [31:0] m_count;

   instruction_fetch #(
      .RESET_PC   (RPC),
      .ROM_DEPTH  (DEPTH),
      .HALT_OPCODE(HOP)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .stall          (stall),
      .redirect       (redirect),
      .redirect_target(redirect_target),
      .rom_address    (rom_address),
      .rom_data       (rom_data),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instruction (if_instruction),
      .fetch_count    (fetch_count),
      .debug_state    (debug_state)
   );

   always #5 clock = ~clock;

   // Registered ROM; bit 32 toggles to show it is ignored.
   always @(posedge clock)
      rom_data <= {~rom_data[32], mem[rom_address % DEPTH]};

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
                  tag, got, got, exp, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_rom_address(input logic stl, input logic rd,
                                                   input logic [31:0] tgt);
      if (rd)                return tgt % DEPTH;
      if (m_valid && stl)    return m_pc;
      return m_next;
   endfunction

   task automatic model_edge(input logic rst, input logic stl, input logic rd,
                             input logic [31:0] tgt);
      logic [31:0] w;
      if (rst) begin
         m_valid = 1'b0; m_halt = 1'b0; m_idle = 1'b1;
         m_pc = RPC % DEPTH; m_next = RPC % DEPTH; m_count = 0;
      end else begin
         w = mem[m_pc];
         if (m_valid && !stl && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
         if (rd) begin
            m_pc = tgt % DEPTH; m_next = (tgt + 1) % DEPTH;
            m_valid = 1'b1; m_halt = 1'b0; m_idle = 1'b0;
         end else if (m_idle) begin
            m_pc = m_next; m_next = (m_next + 1) % DEPTH;
            m_valid = 1'b1; m_idle = 1'b0;
         end else if (m_halt) begin
            m_valid = 1'b0;
         end else if (stl) begin
            // word held
         end else if (w[31:26] == HOP) begin
            m_valid = 1'b0; m_halt = 1'b1;
         end else begin
            m_pc = m_next; m_next = (m_next + 1) % DEPTH;
         end
      end
   endtask

   // One clock: drive inputs, check the combinational address, clock,
   // then check the registered outputs against the model.
   task automatic step(input logic rst, input logic stl, input logic rd,
                       input logic [31:0] tgt);
      @(negedge clock);
      reset = rst; stall = stl; redirect = rd; redirect_target = tgt;
      #1;
      if (!rst) check_eq("rom_address", rom_address, exp_rom_address(stl, rd, tgt));
      @(posedge clock);
      model_edge(rst, stl, rd, tgt);
      #1;
      check_eq("if_valid", 32'(if_valid), 32'(m_valid));
      if (m_valid) begin
         check_eq("if_pc", if_pc, m_pc);
         check_eq("if_instruction", if_instruction, mem[m_pc]);
      end
      check_eq("fetch_count", fetch_count, m_count);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'd0;
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i + 100);
      mem[5] = {HOP, 26'd105};

      // straight-line fetch from reset
      step(1'b1, 1'b0, 1'b0, 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'd0);
      check_eq("reset_valid", 32'(if_valid), 32'd0);
      check_eq("reset_count", fetch_count, 32'd0);
      #1 check_eq("reset_rom_address", rom_address, RPC);
      run(5);
      check_eq("lit_pc4", if_pc, 32'd4);
      check_eq("lit_count4", fetch_count, 32'd4);

      // stall three cycles while pc 2 is offered
      step(1'b1, 1'b0, 1'b0, 32'd0);
      run(3);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0, 32'd0);
         check_eq("lit_stall_pc", if_pc, 32'd2);
         check_eq("lit_stall_instr", if_instruction, 32'd102);
         check_eq("lit_stall_count", fetch_count, 32'd2);
      end
      run(2);
      // now at pc 4: redirect while stalled
      step(1'b0, 1'b1, 1'b1, 32'd9);
      check_eq("lit_redirect_pc", if_pc, 32'd9);
      check_eq("lit_redirect_count", fetch_count, 32'd4);
      run(3);

      // run into the halt word at pc 5
      step(1'b0, 1'b0, 1'b1, 32'd0);
      run(8);
      check_eq("lit_halt_valid", 32'(if_valid), 32'd0);
      step(1'b0, 1'b1, 1'b0, 32'd0);
      step(1'b0, 1'b0, 1'b1, 32'd0);
      check_eq("lit_restart_pc", if_pc, 32'd0);
      run(2);

      // wraparound and out-of-range target
      step(1'b0, 1'b0, 1'b1, 32'd1023);
      check_eq("lit_wrap_hi", if_pc, 32'd1023);
      run(1);
      check_eq("lit_wrap_lo", if_pc, 32'd0);
      step(1'b0, 1'b0, 1'b1, 32'd1030);
      check_eq("lit_mod_target", if_pc, 32'd6);

      // halt with count 7, then reset
      step(1'b1, 1'b0, 1'b0, 32'd0);
      run(8);
      step(1'b0, 1'b0, 1'b1, 32'd5);
      run(3);
      check_eq("lit_halt_count7", fetch_count, 32'd7);
      step(1'b0, 1'b1, 1'b0, 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'd0);
      check_eq("lit_halt_reset_count", fetch_count, 32'd0);
      check_eq("lit_halt_reset_valid", 32'(if_valid), 32'd0);
      #1 check_eq("lit_halt_reset_addr", rom_address, RPC);

      // randomized traffic over random ROM images
      for (int blk = 0; blk < 4; blk++) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] = ($urandom_range(0, 15) == 0) ? {HOP, 26'($urandom)} : $urandom;
         step(1'b1, 1'b0, 1'b0, 32'd0);
         for (int c = 0; c < 500; c++) begin
            logic r_rst, r_stl, r_rd;
            logic [31:0] r_tgt;
            r_rst = ($urandom_range(0, 99) < 2);
            r_stl = ($urandom_range(0, 99) < 30);
            r_rd  = ($urandom_range(0, 99) < 10);
            r_tgt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 2047));
            step(r_rst, r_stl, r_rd, r_tgt);
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
